// File: rtl/case_7_mul_share_arb_pkg.sv
// Shared constants, types and the round-robin pick helper for case_7_mul_share_arb.
// Build option CASE_7_MUL_SHARE_ARB_SAT_EN selects saturation instead of wrap.
package case_7_mul_share_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int MAX_REQ = 8;
  localparam int A_W     = 13;
  localparam int B_W     = 4;
  localparam int R_W     = 13;
  localparam int PROD_W  = A_W + B_W;
  localparam int RES_MAX = 4095;
  localparam int RES_MIN = -4096;

  typedef logic [$clog2(NUM_REQ)-1:0] idx_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Scan ptr+1 .. ptr+n (mod n). The loop runs backwards so the nearest hit wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0] ptr,
                                    input int n);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = n; k >= 1; k--) begin
      idx = (int'(ptr) + k) % n;
      if (valid[idx]) begin
        p.found = 1'b1;
        p.idx   = 3'(idx);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/case_7_mul_share_arb_core.sv
// Combinational signed A x B multiply followed by wrap (default) or saturate
// (CASE_7_MUL_SHARE_ARB_SAT_EN) down to R_W bits.
module case_7_mul_share_arb_core
  import case_7_mul_share_arb_pkg::*;
(
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [R_W-1:0] res,
  output logic           ovf
);

  logic signed [PROD_W-1:0] prod;

  assign prod = $signed(a) * $signed(b);

`ifdef CASE_7_MUL_SHARE_ARB_SAT_EN
  localparam logic signed [PROD_W-1:0] PROD_MAX = PROD_W'(RES_MAX);
  localparam logic signed [PROD_W-1:0] PROD_MIN = PROD_W'(RES_MIN);

  always_comb begin
    res = prod[R_W-1:0];
    ovf = 1'b0;
    if (prod > PROD_MAX) begin
      res = R_W'(RES_MAX);
      ovf = 1'b1;
    end else if (prod < PROD_MIN) begin
      res = R_W'(RES_MIN);
      ovf = 1'b1;
    end
  end
`else
  // Wrap build: the high product bits are intentionally dropped.
  logic unused_hi;
  assign unused_hi = ^prod[PROD_W-1:R_W];
  assign res       = prod[R_W-1:0];
  assign ovf       = 1'b0;
`endif

endmodule

// File: rtl/case_7_mul_share_arb.sv
// Round-robin scheduler sharing one signed multiplier among NREQ requesters.
// Option CASE_7_MUL_SHARE_ARB_SAT_EN saturates results and drives res_ovf.
module case_7_mul_share_arb
  import case_7_mul_share_arb_pkg::*;
#(
  parameter  int NREQ  = NUM_REQ,
  parameter  int CNT_W = 32,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [R_W-1:0]      res_data,
  output logic [ID_W-1:0]     res_id,
  output logic                res_ovf,
  output logic [CNT_W-1:0]    op_count
);

  // Handshake: a transfer happens on a channel in any cycle where valid and
  // ready are both 1 at the rising edge; ready never depends on being granted
  // later, and the result register accepts while it is being drained.
  logic            can_accept;
  logic            accept;
  pick_t           pick;
  logic [ID_W-1:0] g;
  logic [ID_W-1:0] ptr;
  logic [A_W-1:0]  a_sel;
  logic [B_W-1:0]  b_sel;
  logic [R_W-1:0]  core_res;
  logic            core_ovf;

  always_comb begin
    pick       = rr_pick(MAX_REQ'(req_valid), 3'(ptr), NREQ);
    g          = ID_W'(pick.idx);
    can_accept = !res_valid || res_ready;
    accept     = ap_rst_n && can_accept && pick.found;
    req_ready  = '0;
    if (accept) req_ready[g] = 1'b1;
    a_sel      = req_a[g*A_W +: A_W];
    b_sel      = req_b[g*B_W +: B_W];
  end

  case_7_mul_share_arb_core u_core (
    .a   (a_sel),
    .b   (b_sel),
    .res (core_res),
    .ovf (core_ovf)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_ovf   <= 1'b0;
      op_count  <= '0;
      ptr       <= ID_W'(NREQ - 1);
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data  <= core_res;
      res_id    <= g;
      res_ovf   <= core_ovf;
      op_count  <= op_count + CNT_W'(1);
      ptr       <= g;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
